// File: rtl/wb_drp_multi_if.sv
// Wishbone slave-side bus bundle for the multi-channel DRP bridge.
// The address carries {channel, DRP address}; data is fixed at 16 bits.
interface wb_drp_multi_if #(
    parameter int ADR_WIDTH = 12
);
    logic [ADR_WIDTH-1:0] wb_adr_i;
    logic [15:0]          wb_dat_i;
    logic [15:0]          wb_dat_o;
    logic                 wb_we_i;
    logic                 wb_stb_i;
    logic                 wb_cyc_i;
    logic                 wb_ack_o;
    logic                 wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_drp_multi.sv
// Wishbone-to-DRP bridge fanning one bus master out to CHANNELS DRP ports.
// Shared address/data, per-channel enable/ready, with timeout and abort handling.
module wb_drp_multi #(
    parameter int CHANNELS   = 4,
    parameter int CH_WIDTH   = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wb_drp_multi_if.slave            wb,
    output logic [ADDR_WIDTH-1:0]    drp_addr,
    output logic [15:0]              drp_do,
    input  logic [CHANNELS*16-1:0]   drp_di,
    output logic [CHANNELS-1:0]      drp_en,
    output logic [CHANNELS-1:0]      drp_we,
    input  logic [CHANNELS-1:0]      drp_rdy,
    output logic [15:0]              timeout_count
);
    localparam int DW = 16;
    localparam logic [CH_WIDTH:0] NUM_CH = (CH_WIDTH + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_r;
    logic [CH_WIDTH-1:0]   ch_r;
    logic [7:0]            timer_r;
    logic                  we_r;
    logic                  first_r;
    logic                  abort_r;

    logic [CH_WIDTH-1:0]   req_ch_s;
    logic                  req_valid_s;
    logic [CHANNELS-1:0]   req_onehot_s;
    logic                  rdy_sel_s;
    logic [15:0]           di_sel_s;
    logic                  abort_s;

    assign req_ch_s    = wb.wb_adr_i[CH_WIDTH+ADDR_WIDTH-1 -: CH_WIDTH];
    assign req_valid_s = ({1'b0, req_ch_s} < NUM_CH);
    // A master that drops cyc at any point of the wait loses its response.
    assign abort_s     = abort_r | ~wb.wb_cyc_i;

    // Channel decode for the request and selection of the active channel's ready/data.
    always_comb begin
        req_onehot_s = {CHANNELS{1'b0}};
        rdy_sel_s    = 1'b0;
        di_sel_s     = 16'h0000;
        for (int i = 0; i < CHANNELS; i++) begin
            req_onehot_s[i] = (req_ch_s == CH_WIDTH'(i));
            rdy_sel_s       = rdy_sel_s | (drp_rdy[i] & (ch_r == CH_WIDTH'(i)));
            di_sel_s        = di_sel_s | (drp_di[DW*i +: DW] & {16{ch_r == CH_WIDTH'(i)}});
        end
    end

    // Bridge control FSM with all bus-facing outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            ch_r          <= {CH_WIDTH{1'b0}};
            timer_r       <= 8'd0;
            we_r          <= 1'b0;
            first_r       <= 1'b0;
            abort_r       <= 1'b0;
            wb.wb_ack_o   <= 1'b0;
            wb.wb_err_o   <= 1'b0;
            wb.wb_dat_o   <= 16'h0000;
            drp_en        <= {CHANNELS{1'b0}};
            drp_we        <= {CHANNELS{1'b0}};
            drp_addr      <= {ADDR_WIDTH{1'b0}};
            drp_do        <= 16'h0000;
            timeout_count <= 16'h0000;
        end else begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            drp_en      <= {CHANNELS{1'b0}};
            drp_we      <= {CHANNELS{1'b0}};
            case (state_r)
                IDLE: begin
                    if (wb.wb_cyc_i && wb.wb_stb_i) begin
                        if (req_valid_s) begin
                            ch_r     <= req_ch_s;
                            drp_addr <= wb.wb_adr_i[ADDR_WIDTH-1:0];
                            drp_do   <= wb.wb_dat_i;
                            drp_en   <= req_onehot_s;
                            drp_we   <= wb.wb_we_i ? req_onehot_s : {CHANNELS{1'b0}};
                            we_r     <= wb.wb_we_i;
                            timer_r  <= 8'(TIMEOUT);
                            first_r  <= 1'b1;
                            abort_r  <= 1'b0;
                            state_r  <= WAIT;
                        end else begin
                            wb.wb_err_o <= 1'b1;
                            state_r     <= RESP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    first_r <= 1'b0;
                    abort_r <= abort_s;
                    // The enable cycle itself cannot carry ready; the countdown starts after it.
                    if (first_r) begin
                        state_r <= WAIT;
                    end else if (rdy_sel_s) begin
                        if (!we_r) begin
                            wb.wb_dat_o <= di_sel_s;
                        end else begin
                            wb.wb_dat_o <= wb.wb_dat_o;
                        end
                        wb.wb_ack_o <= ~abort_s;
                        state_r     <= RESP;
                    end else if (timer_r == 8'd0) begin
                        wb.wb_err_o   <= ~abort_s;
                        timeout_count <= (timeout_count == 16'hFFFF) ? timeout_count
                                                                     : timeout_count + 16'd1;
                        state_r       <= RESP;
                    end else begin
                        timer_r <= timer_r - 8'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/wb_drp_multi.md
WB_DRP_MULTI -- requirements
Module: wb_drp_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of DRP ports bridged (1..2**CH_WIDTH).
REQ-002 SHALL have parameter CH_WIDTH, default 2, channel-select address bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, DRP address width.
REQ-004 SHALL have parameter TIMEOUT, default 255, DRP wait cycles before error (8-bit range, 1..255).
REQ-005 SHALL have ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- wb_adr_i  in  CH_WIDTH+ADDR_WIDTH  {channel, DRP address}.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  completion.
- wb_err_o  out  1  error completion.
- drp_addr  out  ADDR_WIDTH  shared DRP address.
- drp_do  out  16  shared DRP write data.
- drp_di  in  CHANNELS*16  per-channel read data; channel n at [16n+15:16n].
- drp_en  out  CHANNELS  per-channel enable.
- drp_we  out  CHANNELS  per-channel write enable.
- drp_rdy  in  CHANNELS  per-channel ready.
- timeout_count  out  16  saturating count of DRP timeouts.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-007 IDLE, cyc&&stb sampled at cycle 0, channel ch = wb_adr_i[top CH_WIDTH bits] < CHANNELS: at cycle 1 drp_addr/drp_do hold latched address/data, drp_en[ch]=1, drp_we[ch]=wb_we_i, for exactly one cycle; timer loaded TIMEOUT; state -> WAIT.
REQ-008 IDLE, ch >= CHANNELS: no DRP access; wb_err_o=1 at cycle 1 for one cycle; state -> RESP.
REQ-009 drp_en and drp_we SHALL never have more than one bit set; drp_we only high together with drp_en on the same bit.
REQ-010 WAIT, drp_rdy[ch]=1: latch drp_di slice ch into wb_dat_o (writes: wb_dat_o unchanged); wb_ack_o=1 next cycle for one cycle; state -> RESP.
REQ-011 WAIT, drp_rdy[ch]=0: timer==0 -> wb_err_o=1 next cycle for one cycle, timeout_count+1 (saturates at 16'hFFFF), state -> RESP; else timer decrements.
REQ-012 With DRP enable at cycle 1, a silent channel SHALL produce wb_err_o at cycle TIMEOUT+3.
REQ-013 drp_rdy on channels other than ch SHALL be ignored in all states; drp_rdy in IDLE/RESP ignored.
REQ-014 drp_rdy and timer==0 in the same cycle: rdy wins, ack not err, no count.
REQ-015 wb_cyc_i deasserted during WAIT: DRP access still completes (rdy or timeout); the resulting ack/err SHALL be suppressed; timeout still counted.
REQ-016 RESP lasts one cycle (the ack/err cycle); stb is not sampled in RESP; state -> IDLE. Minimum request spacing is thus one idle cycle after ack/err.
REQ-017 wb_ack_o and wb_err_o SHALL never be high together.
REQ-018 drp_addr, drp_do hold last latched values between accesses.

Reset
REQ-019 rst_n low at a clock edge SHALL force IDLE, timer 0, and outputs wb_ack_o=0, wb_err_o=0, wb_dat_o=0, drp_en=0, drp_we=0, drp_addr=0, drp_do=0, timeout_count=0.
REQ-020 Reset mid-WAIT SHALL abandon the access with no ack/err; a later drp_rdy is ignored.

Verification
REQ-021 Read ch 2 addr 0x05A, drp_rdy[2] 3 cycles after en with drp_di[47:32]=0xBEEF -> drp_en=4'b0100 one cycle, drp_addr=0x05A, ack one cycle after rdy, wb_dat_o=0xBEEF.
REQ-022 Write ch 0 addr 0x3FF data 0x1234 -> drp_en=drp_we=4'b0001 one cycle, drp_do=0x1234, ack after rdy[0]; rdy[1] pulses during WAIT ignored.
REQ-023 CHANNELS=3, access ch 3 -> no drp_en, wb_err_o at cycle 1, timeout_count unchanged.
REQ-024 TIMEOUT=4, no rdy -> err at cycle 7, timeout_count=1; rdy exactly on timer==0 cycle -> ack, count unchanged.
REQ-025 cyc dropped in WAIT then rdy -> no ack/err; next request served normally; rst_n low mid-WAIT -> all outputs reset values, late rdy ignored.
